// File: rtl/psa_arbiter.sv
// Round-robin arbiter sharing one 4x4-bit signed saturating lane adder between two requesters.
// Latency: operands accepted at edge N are presented on res_* after edge N (one register stage).
// Backpressure: readys drop while the output slot is full and res_ready=0; drain and refill in the same cycle.
module psa_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [15:0]      req0_a,
  input  logic [15:0]      req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [15:0]      req1_a,
  input  logic [15:0]      req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [15:0]      res_sum,
  output logic             res_err,
  output logic             res_id,
  input  logic             res_ready,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef struct packed {
    logic [15:0] sum;
    logic        err;
    logic        id;
  } res_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  res_t             slot;
  logic             slot_vld;
  logic             prio;
  logic [CNT_W-1:0] cnt;

  logic             any_vld;
  logic             grant;
  logic             slot_free;
  logic             accept;
  logic [15:0]      op_a;
  logic [15:0]      op_b;
  logic [16:0]      add_out;
  res_t             nxt;

  // Four independent 4-bit lanes; signed overflow clamps, unsigned carry-out of any lane flags err.
  function automatic logic [16:0] psa_add(input logic [15:0] a, input logic [15:0] b);
    logic [4:0]  s;
    logic [15:0] sum;
    logic        err;
    sum = '0;
    err = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s   = {1'b0, a[4*k+:4]} + {1'b0, b[4*k+:4]};
      err = err | s[4];
      if (!a[4*k+3] && !b[4*k+3] && s[3]) begin
        sum[4*k+:4] = 4'h7;
      end else if (a[4*k+3] && b[4*k+3] && !s[3]) begin
        sum[4*k+:4] = 4'h8;
      end else begin
        sum[4*k+:4] = s[3:0];
      end
    end
    return {err, sum};
  endfunction

  // Grant selection: a lone requester wins, contention is broken by prio.
  always_comb begin
    any_vld = req0_valid | req1_valid;
    grant   = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = prio;
    end else begin
      grant = req1_valid;
    end
  end

  // rst_n gates the handshake so no requester sees ready while reset is asserted.
  assign slot_free  = !slot_vld | res_ready;
  assign accept     = rst_n & slot_free & any_vld;
  assign req0_ready = accept & !grant;
  assign req1_ready = accept & grant;

  // Operand mux feeding the single shared adder.
  always_comb begin
    op_a    = grant ? req1_a : req0_a;
    op_b    = grant ? req1_b : req0_b;
    add_out = psa_add(op_a, op_b);
    nxt.sum = add_out[15:0];
    nxt.err = add_out[16];
    nxt.id  = grant;
  end

  // Output slot and round-robin pointer; prio only moves when a transfer completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot     <= '0;
      slot_vld <= 1'b0;
      prio     <= 1'b0;
    end else if (accept) begin
      slot     <= nxt;
      slot_vld <= 1'b1;
      prio     <= !grant;
    end else if (slot_free) begin
      slot_vld <= 1'b0;
    end
  end

  // Saturating error counter; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr_cnt) begin
      cnt <= '0;
    end else if (accept && nxt.err && cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign res_valid = slot_vld;
  assign res_sum   = slot.sum;
  assign res_err   = slot.err;
  assign res_id    = slot.id;
  assign err_cnt   = cnt;

endmodule

// File: tb/tb_psa_arbiter.sv
// Bench for psa_arbiter: randomized and directed traffic scored against a lane-arithmetic model.
// Latency: expected results enter the scoreboard on the accepting edge and are compared while presented.
// Backpressure: the driver holds operands until accepted; res_ready is toggled to exercise stalls.
module tb_psa_arbiter;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0;
  logic [15:0]      req0_a = '0;
  logic [15:0]      req0_b = '0;
  logic             req0_ready;
  logic             req1_valid = 1'b0;
  logic [15:0]      req1_a = '0;
  logic [15:0]      req1_b = '0;
  logic             req1_ready;
  logic             res_valid;
  logic [15:0]      res_sum;
  logic             res_err;
  logic             res_id;
  logic             res_ready = 1'b0;
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] err_cnt;

  always #5 clk = ~clk;

  psa_arbiter #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_ready(req1_ready),
    .res_valid (res_valid),
    .res_sum   (res_sum),
    .res_err   (res_err),
    .res_id    (res_id),
    .res_ready (res_ready),
    .clr_cnt   (clr_cnt),
    .err_cnt   (err_cnt)
  );

  typedef struct {
    logic [15:0] sum;
    logic        err;
    logic        id;
  } exp_t;

  exp_t q[$];
  bit   m_full;
  bit   m_prio;
  int   m_cnt;
  int   checks;
  int   errors;

  bit          pend;
  bit          p_acc;
  bit          p_free;
  bit          p_w;
  bit          p_clr;
  logic [15:0] p_a;
  logic [15:0] p_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: lanes as signed integers, clamp to [-8,7]; err when any unsigned lane sum exceeds 15.
  function automatic logic [16:0] model_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        e;
    int          sa, sb, s;
    r = '0;
    e = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sa = int'(a[4*k+:4]);
      sb = int'(b[4*k+:4]);
      if (sa + sb > 15) e = 1'b1;
      if (sa > 7) sa -= 16;
      if (sb > 7) sb -= 16;
      s = sa + sb;
      if (s > 7) s = 7;
      if (s < -8) s = -8;
      r[4*k+:4] = s[3:0];
    end
    return {e, r};
  endfunction

  // Predictor: decide the expected winner before the edge, commit the model on the edge.
  always begin
    logic [16:0] r;
    exp_t        e;
    @(negedge clk);
    pend = 1'b0;
    if (rst_n) begin
      p_free = !m_full || res_ready;
      p_acc  = (req0_valid || req1_valid) && p_free;
      p_w    = (req0_valid && req1_valid) ? m_prio : req1_valid;
      chk("req0_ready", req0_ready, p_acc && !p_w);
      chk("req1_ready", req1_ready, p_acc && p_w);
      p_a   = p_w ? req1_a : req0_a;
      p_b   = p_w ? req1_b : req0_b;
      p_clr = clr_cnt;
      pend  = 1'b1;
    end
    @(posedge clk);
    if (pend && rst_n) begin
      r = model_add(p_a, p_b);
      if (p_acc) begin
        e.sum = r[15:0];
        e.err = r[16];
        e.id  = p_w;
        q.push_back(e);
        m_full = 1'b1;
        m_prio = !p_w;
      end else if (p_free) begin
        m_full = 1'b0;
      end
      if (p_clr) m_cnt = 0;
      else if (p_acc && r[16] && m_cnt < CNT_MAX) m_cnt++;
    end
  end

  // Monitor: compare the presented result against the scoreboard head, retire it when drained.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("err_cnt", err_cnt, m_cnt);
      chk("res_valid", res_valid, q.size() != 0);
      if (res_valid && q.size() != 0) begin
        chk("res_sum", res_sum, q[0].sum);
        chk("res_err", res_err, q[0].err);
        chk("res_id", res_id, q[0].id);
        if (res_ready) void'(q.pop_front());
      end
    end
  end

  // One cycle of stimulus; a requester only gets new operands once its previous ones were taken.
  task automatic drive_cycle(input int p0, input int p1, input bit rr, input bit clr,
                             input bit fix, input logic [15:0] fa, input logic [15:0] fb);
    bit a0, a1;
    @(negedge clk);
    a0 = req0_valid && req0_ready;
    a1 = req1_valid && req1_ready;
    @(posedge clk);
    #1;
    if (!req0_valid || a0) begin
      req0_valid = ($urandom_range(99) < p0);
      req0_a     = fix ? fa : 16'($urandom);
      req0_b     = fix ? fb : 16'($urandom);
    end
    if (!req1_valid || a1) begin
      req1_valid = ($urandom_range(99) < p1);
      req1_a     = fix ? fa : 16'($urandom);
      req1_b     = fix ? fb : 16'($urandom);
    end
    res_ready = rr;
    clr_cnt   = clr;
  endtask

  initial begin
    bit seen;
    // Reset state, including readys held low while requests are pending.
    #1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    res_ready  = 1'b1;
    #2;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_sum", res_sum, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Basic add, then positive and negative saturation from requester 1.
    drive_cycle(100, 0, 1, 0, 1, 16'h1234, 16'h1111);
    drive_cycle(0, 100, 1, 0, 1, 16'h7777, 16'h1111);
    drive_cycle(0, 100, 1, 0, 1, 16'h8888, 16'h8888);
    repeat (2) drive_cycle(0, 0, 1, 0, 0, 16'h0, 16'h0);

    // Round robin under continuous contention.
    repeat (8) drive_cycle(100, 100, 1, 0, 0, 16'h0, 16'h0);

    // Backpressure: stall three cycles, then release.
    repeat (3) drive_cycle(100, 100, 0, 0, 0, 16'h0, 16'h0);
    repeat (4) drive_cycle(100, 100, 1, 0, 0, 16'h0, 16'h0);
    repeat (2) drive_cycle(0, 0, 1, 0, 0, 16'h0, 16'h0);

    // Counter saturation, then clear colliding with an err accept.
    drive_cycle(0, 0, 1, 1, 0, 16'h0, 16'h0);
    repeat (5) drive_cycle(100, 0, 1, 0, 1, 16'h8888, 16'h8888);
    drive_cycle(100, 0, 1, 1, 1, 16'h8888, 16'h8888);
    repeat (2) drive_cycle(0, 0, 1, 0, 0, 16'h0, 16'h0);

    // Random mix of contention, stalls, clears and overflowing operands.
    repeat (400) drive_cycle(60, 60, $urandom_range(99) < 70, $urandom_range(99) < 5,
                             $urandom_range(99) < 20, 16'h8888, 16'h8888);

    // Asynchronous reset between edges while a result is held.
    repeat (3) drive_cycle(100, 100, 1, 0, 1, 16'h8888, 16'h8888);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_res_valid: got timeout expected res_valid=1");
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_res_valid", res_valid, 0);
    chk("arst_res_sum", res_sum, 0);
    chk("arst_res_err", res_err, 0);
    chk("arst_res_id", res_id, 0);
    chk("arst_err_cnt", err_cnt, 0);
    chk("arst_req0_ready", req0_ready, 0);
    chk("arst_req1_ready", req1_ready, 0);
    q.delete();
    m_full = 1'b0;
    m_prio = 1'b0;
    m_cnt  = 0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) drive_cycle(100, 100, 1, 0, 0, 16'h0, 16'h0);
    repeat (4) drive_cycle(0, 0, 1, 0, 0, 16'h0, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/psa_arbiter.md
# psa_arbiter

Two-requester round-robin arbiter in front of one shared 16-bit paired sub-word adder (four independent 4-bit signed saturating lanes plus a carry error flag). It lets the execute-stage ALU and the secondary (vector/DMA-side) requester share a single adder instance. The result passes through one registered output slot with valid/ready backpressure. The block also keeps a saturating count of results that raised the error flag.

## Interface
Parameters:
- CNT_W, 8, width of the error counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_a, req0_b  in  16  requester 0 operands.
- req0_ready  out  1  requester 0 operands are accepted this cycle.
- req1_valid, req1_a, req1_b, req1_ready: same as the requester 0 ports, for requester 1.
- res_valid  out  1  the output slot holds a result.
- res_sum  out  16  lane-saturated sum.
- res_err  out  1  error flag of the result.
- res_id  out  1  which requester produced the result (0/1).
- res_ready  in  1  consumer accepts the result this cycle.
- clr_cnt  in  1  synchronous clear of err_cnt.
- err_cnt  out  CNT_W  count of accepted results with err=1.

## Operation
- **Adder function**, per lane k (bits 4k+3:4k):
  - s = a_k + b_k (4-bit).
  - If a_k[3]=b_k[3]=0 and s[3]=1, the lane result is 0111.
  - Else if a_k[3]=b_k[3]=1 and s[3]=0, the lane result is 1000.
  - Otherwise the lane result is s.
  - err = OR over all four lanes of the unsigned carry-out of a_k+b_k. Lanes never carry into one another.
- **Slot free:** slot_free = !res_valid | res_ready.
- **Grant** (combinational):
  - If only one requester is valid, it wins.
  - If both are valid, the requester named by the priority bit prio wins.
  - If neither is valid, there is no grant.
- **Handshake:**
  - reqN_ready = slot_free & (grant == N).
  - ready may depend on valid. The requester must hold valid and operands stable until the cycle in which ready=1.
- **Accept** (a transfer completes when valid & ready):
  - On the edge, the output slot loads the sum, err and id of the winner, and res_valid is set to 1.
  - prio is set to the non-winner.
- **No accept:**
  - If slot_free is true and nothing is accepted, res_valid is cleared to 0.
  - If the slot holds a result and res_ready=0, all slot outputs hold their values and both readys are 0.
- **Error counter:**
  - Increments on an accept with err=1 and saturates at 2^CNT_W−1.
  - clr_cnt=1 sets it to 0 and takes precedence over a same-cycle increment.
- **Starvation:** with both requesters continuously valid and res_ready=1, grants alternate 0,1,0,1…

## Timing
- **Reset:** asserting rst_n=0 immediately forces all of the following, regardless of clk:
  - res_valid=0, res_sum=0, res_err=0, res_id=0.
  - err_cnt=0, prio=0.
  - reqN_ready=0 while in reset.
  - A pending result is discarded.
  - After reset, the first edge with valid input can accept.
- **Latency:** an operand pair accepted at edge N appears on res_* after edge N, stable in cycle N+1.
- **Throughput:** one result per cycle when res_ready stays 1.
- **Simultaneous drain and accept:** a new result can be accepted in the same cycle the old one is drained (res_valid & res_ready). There is no bubble.
- **Backpressure:** input is accepted in the same cycle res_ready rises.
- **Priority updates:** prio changes only on an accept. Stall cycles and idle cycles leave it unchanged.
- **Counter visibility:** an err_cnt increment is visible in the same cycle as the corresponding res_valid.

## Test plan
- **Basic add, no overflow:** after reset, req0 presents a=0x1234, b=0x1111 with res_ready=1.
  - Required: req0_ready=1 that cycle.
  - Next cycle: res_valid=1, res_sum=0x2345, res_err=0, res_id=0, err_cnt=0.
- **Positive and negative saturation:**
  - req1 presents a=0x7777, b=0x1111. Required: res_sum=0x7777, res_err=0, res_id=1.
  - Then req1 presents a=0x8888, b=0x8888. Required: res_sum=0x8888, res_err=1, err_cnt=1.
- **Round-robin fairness:** both requesters continuously valid from reset, res_ready=1.
  - Required: res_id sequence 0,1,0,1 over four cycles, with no idle cycle.
- **Backpressure:** hold res_ready=0 for 3 cycles with both requesters valid.
  - Required: after the first result, both readys=0 and res_* held unchanged.
  - When res_ready rises: the held result drains and the next result loads in the same cycle; that next result comes from the other requester.
- **Counter saturation and clear:** with CNT_W=2, feed 5 accepts with a=b=0x8888.
  - Required: err_cnt runs 1,2,3,3,3.
  - Assert clr_cnt in the same cycle as a further err accept. Required: err_cnt=0.
- **Async reset mid-stream:** drop rst_n between clock edges while res_valid=1.
  - Required: res_valid, res_sum and err_cnt go to 0 before the next edge.
  - After release with both requesters valid, the first grant goes to requester 0.
